// File: rtl/rob_commit.sv
`default_nettype none
//============================================================================
// Module  : rob_commit
// Brief   : Reorder buffer - tag allocation, operand resolution against
//           in-flight results, in-order commit and misprediction flush.
// Rev     : 1.0
//============================================================================

module rob_commit #(
    parameter int ROB_ADD_W = 4,
    parameter int REG_ADD_W = 5,
    parameter int REG_DAT_W = 32,
    parameter int INS_OP_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIS_En,
    input  logic [REG_ADD_W-1:0] iIS_Rd,
    input  logic                 iIS_Br,
    output logic                 oIS_Full,
    output logic [ROB_ADD_W-1:0] oRF_Qn,
    input  logic                 iRF_En,
    input  logic [ROB_ADD_W-1:0] iRF_Qs1,
    input  logic [ROB_ADD_W-1:0] iRF_Qs2,
    input  logic [REG_DAT_W-1:0] iRF_Vs1,
    input  logic [REG_DAT_W-1:0] iRF_Vs2,
    input  logic [ROB_ADD_W-1:0] iRF_Qd,
    input  logic [INS_OP_W-1:0]  iRF_Op,
    input  logic [REG_DAT_W-1:0] iRF_Pc,
    input  logic [REG_DAT_W-1:0] iRF_Imm,
    input  logic                 iCDB_En,
    input  logic [ROB_ADD_W-1:0] iCDB_Q,
    input  logic [REG_DAT_W-1:0] iCDB_V,
    input  logic                 iCDB_Mp,
    input  logic [REG_DAT_W-1:0] iCDB_Pc,
    output logic                 oRS_En,
    output logic [ROB_ADD_W-1:0] oRS_Qj,
    output logic [ROB_ADD_W-1:0] oRS_Qk,
    output logic [REG_DAT_W-1:0] oRS_Vj,
    output logic [REG_DAT_W-1:0] oRS_Vk,
    output logic [ROB_ADD_W-1:0] oRS_Qd,
    output logic [INS_OP_W-1:0]  oRS_Op,
    output logic [REG_DAT_W-1:0] oRS_Pc,
    output logic [REG_DAT_W-1:0] oRS_Imm,
    output logic                 oRF_En,
    output logic [REG_ADD_W-1:0] oRF_Rd,
    output logic [REG_DAT_W-1:0] oRF_Vd,
    output logic                 oMp,
    output logic [REG_DAT_W-1:0] oMp_Pc
);

    localparam int                   DEPTH = 1 << ROB_ADD_W;
    localparam logic [ROB_ADD_W-1:0] C_CAP = ROB_ADD_W'(DEPTH - 1);
    localparam logic [ROB_ADD_W-1:0] C_ONE = ROB_ADD_W'(1);

    logic [DEPTH-1:0]     r_busy, r_ready, r_br, r_mp;
    logic [REG_ADD_W-1:0] r_rd     [DEPTH];
    logic [REG_DAT_W-1:0] r_value  [DEPTH];
    logic [REG_DAT_W-1:0] r_target [DEPTH];
    logic [ROB_ADD_W-1:0] r_head, r_tail, r_count;

    logic                 w_commit, w_flush, w_issue, w_cdb_hit, w_dispatch;
    logic [ROB_ADD_W-1:0] w_qj, w_qk;
    logic [REG_DAT_W-1:0] w_vj, w_vk;

    // Tag 0 is reserved for "no dependency", so pointers wrap CAP -> 1.
    function automatic logic [ROB_ADD_W-1:0] f_next(input logic [ROB_ADD_W-1:0] t);
        return (t == C_CAP) ? C_ONE : t + C_ONE;
    endfunction

    function automatic logic [ROB_ADD_W+REG_DAT_W-1:0] f_resolve(
        input logic [ROB_ADD_W-1:0] qs,
        input logic [REG_DAT_W-1:0] vs
    );
        if (qs == '0)
            return {{ROB_ADD_W{1'b0}}, vs};
        else if (r_ready[qs] || !r_busy[qs])
            return {{ROB_ADD_W{1'b0}}, r_value[qs]};
        else if (iCDB_En && (iCDB_Q == qs))
            return {{ROB_ADD_W{1'b0}}, iCDB_V};
        else
            return {qs, {REG_DAT_W{1'b0}}};
    endfunction

    assign {w_qj, w_vj} = f_resolve(iRF_Qs1, iRF_Vs1);
    assign {w_qk, w_vk} = f_resolve(iRF_Qs2, iRF_Vs2);

    assign oIS_Full   = (r_count == C_CAP);
    assign oRF_Qn     = r_tail;
    assign w_commit   = r_busy[r_head] && r_ready[r_head];
    assign w_flush    = w_commit && r_br[r_head] && r_mp[r_head];
    // Inputs arriving while oMp is high belong to the squashed path.
    assign w_issue    = iIS_En && !oIS_Full && !oMp;
    assign w_cdb_hit  = iCDB_En && !oMp && r_busy[iCDB_Q];
    assign w_dispatch = iRF_En && !oMp && !w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_br    <= '0;
            r_mp    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]     <= '0;
                r_value[i]  <= '0;
                r_target[i] <= '0;
            end
            r_head  <= C_ONE;
            r_tail  <= C_ONE;
            r_count <= '0;
            oRS_En  <= 1'b0;
            oRS_Qj  <= '0;
            oRS_Qk  <= '0;
            oRS_Vj  <= '0;
            oRS_Vk  <= '0;
            oRS_Qd  <= '0;
            oRS_Op  <= '0;
            oRS_Pc  <= '0;
            oRS_Imm <= '0;
            oRF_En  <= 1'b0;
            oRF_Rd  <= '0;
            oRF_Vd  <= '0;
            oMp     <= 1'b0;
            oMp_Pc  <= '0;
        end else if (en) begin
            oRF_En <= w_commit;
            if (w_commit) begin
                oRF_Rd <= r_rd[r_head];
                oRF_Vd <= r_value[r_head];
            end
            oMp <= w_flush;
            if (w_flush)
                oMp_Pc <= r_target[r_head];
            oRS_En <= w_dispatch;
            if (w_dispatch) begin
                oRS_Qj  <= w_qj;
                oRS_Vj  <= w_vj;
                oRS_Qk  <= w_qk;
                oRS_Vk  <= w_vk;
                oRS_Qd  <= iRF_Qd;
                oRS_Op  <= iRF_Op;
                oRS_Pc  <= iRF_Pc;
                oRS_Imm <= iRF_Imm;
            end
            if (w_flush) begin
                r_busy  <= '0;
                r_head  <= C_ONE;
                r_tail  <= C_ONE;
                r_count <= '0;
            end else begin
                if (w_cdb_hit) begin
                    r_ready[iCDB_Q]  <= 1'b1;
                    r_value[iCDB_Q]  <= iCDB_V;
                    r_mp[iCDB_Q]     <= iCDB_Mp;
                    r_target[iCDB_Q] <= iCDB_Pc;
                end
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_mp[r_tail]    <= 1'b0;
                    r_br[r_tail]    <= iIS_Br;
                    r_rd[r_tail]    <= iIS_Rd;
                    r_tail          <= f_next(r_tail);
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= f_next(r_head);
                end
                r_count <= r_count + ROB_ADD_W'(w_issue) - ROB_ADD_W'(w_commit);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
//============================================================================
// Module  : tb_rob_commit
// Brief   : Directed scenarios plus randomized traffic against a queue-based
//           reorder-buffer reference model.
// Rev     : 1.0
//============================================================================

module tb_rob_commit;

    localparam int RW = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst, en;
    logic          iIS_En, iIS_Br;
    logic [AW-1:0] iIS_Rd;
    logic          oIS_Full;
    logic [RW-1:0] oRF_Qn;
    logic          iRF_En;
    logic [RW-1:0] iRF_Qs1, iRF_Qs2, iRF_Qd;
    logic [DW-1:0] iRF_Vs1, iRF_Vs2, iRF_Pc, iRF_Imm;
    logic [OW-1:0] iRF_Op;
    logic          iCDB_En, iCDB_Mp;
    logic [RW-1:0] iCDB_Q;
    logic [DW-1:0] iCDB_V, iCDB_Pc;
    logic          oRS_En, oRF_En, oMp;
    logic [RW-1:0] oRS_Qj, oRS_Qk, oRS_Qd;
    logic [DW-1:0] oRS_Vj, oRS_Vk, oRS_Pc, oRS_Imm, oRF_Vd, oMp_Pc;
    logic [OW-1:0] oRS_Op;
    logic [AW-1:0] oRF_Rd;

    rob_commit #(.ROB_ADD_W(RW), .REG_ADD_W(AW), .REG_DAT_W(DW), .INS_OP_W(OW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .iIS_En(iIS_En), .iIS_Rd(iIS_Rd), .iIS_Br(iIS_Br),
        .oIS_Full(oIS_Full), .oRF_Qn(oRF_Qn),
        .iRF_En(iRF_En), .iRF_Qs1(iRF_Qs1), .iRF_Qs2(iRF_Qs2),
        .iRF_Vs1(iRF_Vs1), .iRF_Vs2(iRF_Vs2), .iRF_Qd(iRF_Qd),
        .iRF_Op(iRF_Op), .iRF_Pc(iRF_Pc), .iRF_Imm(iRF_Imm),
        .iCDB_En(iCDB_En), .iCDB_Q(iCDB_Q), .iCDB_V(iCDB_V),
        .iCDB_Mp(iCDB_Mp), .iCDB_Pc(iCDB_Pc),
        .oRS_En(oRS_En), .oRS_Qj(oRS_Qj), .oRS_Qk(oRS_Qk),
        .oRS_Vj(oRS_Vj), .oRS_Vk(oRS_Vk), .oRS_Qd(oRS_Qd),
        .oRS_Op(oRS_Op), .oRS_Pc(oRS_Pc), .oRS_Imm(oRS_Imm),
        .oRF_En(oRF_En), .oRF_Rd(oRF_Rd), .oRF_Vd(oRF_Vd),
        .oMp(oMp), .oMp_Pc(oMp_Pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: program-ordered queue of in-flight instructions.
    typedef struct {
        logic [RW-1:0] tag;
        logic [AW-1:0] rd;
        bit            br;
        bit            rdy;
        bit            mp;
        logic [DW-1:0] tgt;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] mvals [16];
    int            mtail = 1;
    logic          e_rs_en = 0, e_rf_en = 0, e_mp = 0;
    logic [RW-1:0] e_qj, e_qk, e_qd;
    logic [DW-1:0] e_vj, e_vk, e_pc, e_imm, e_vd, e_mppc;
    logic [OW-1:0] e_op;
    logic [AW-1:0] e_rd;

    function automatic int m_find(input logic [RW-1:0] t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic m_resolve(input logic [RW-1:0] qs, input logic [DW-1:0] vs,
                             output logic [RW-1:0] q, output logic [DW-1:0] v);
        int k;
        k = m_find(qs);
        if (qs == 0) begin q = 0; v = vs; end
        else if (k < 0 || mq[k].rdy) begin q = 0; v = mvals[qs]; end
        else if (iCDB_En && iCDB_Q == qs) begin q = 0; v = iCDB_V; end
        else begin q = qs; v = 0; end
    endtask

    task automatic m_step();
        bit   commit, flush, kill;
        int   k;
        ent_t n;
        if (rst) begin
            mq.delete();
            mtail = 1;
            for (int i = 0; i < 16; i++) mvals[i] = 0;
            e_rs_en = 0; e_rf_en = 0; e_mp = 0; e_mppc = 0;
            return;
        end
        if (!en) return;
        commit  = (mq.size() > 0) && mq[0].rdy;
        flush   = commit && mq[0].br && mq[0].mp;
        kill    = flush || e_mp;
        e_rf_en = commit;
        if (commit) begin e_rd = mq[0].rd; e_vd = mvals[mq[0].tag]; end
        e_rs_en = iRF_En && !kill;
        if (e_rs_en) begin
            m_resolve(iRF_Qs1, iRF_Vs1, e_qj, e_vj);
            m_resolve(iRF_Qs2, iRF_Vs2, e_qk, e_vk);
            e_qd = iRF_Qd; e_op = iRF_Op; e_pc = iRF_Pc; e_imm = iRF_Imm;
        end
        if (flush) begin
            e_mppc = mq[0].tgt;
            mq.delete();
            mtail = 1;
        end else begin
            if (iCDB_En && !e_mp) begin
                k = m_find(iCDB_Q);
                if (k >= 0) begin
                    n = mq[k]; n.rdy = 1; n.mp = iCDB_Mp; n.tgt = iCDB_Pc; mq[k] = n;
                    mvals[iCDB_Q] = iCDB_V;
                end
            end
            if (iIS_En && mq.size() < 15 && !e_mp) begin
                n.tag = RW'(mtail); n.rd = iIS_Rd; n.br = iIS_Br;
                n.rdy = 0; n.mp = 0; n.tgt = 0;
                mq.push_back(n);
                mtail = (mtail == 15) ? 1 : mtail + 1;
            end
            if (commit) void'(mq.pop_front());
        end
        e_mp = flush;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        iIS_En = 0; iRF_En = 0; iCDB_En = 0; iCDB_Mp = 0;
    endtask

    task automatic do_reset();
        en = 1; rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({oRS_En, oRF_En, oMp, oRS_Qj, oRS_Qk, oRS_Vj, oRS_Vk, oRS_Qd, oRS_Op, oRS_Pc, oRS_Imm,
             oRF_Rd, oRF_Vd, oMp_Pc} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got rs_en=%b rf_en=%b mp=%b vd=%h want all zero",
                              oRS_En, oRF_En, oMp, oRF_Vd);
        end
        n_vec++;
        if ({oIS_Full, oRF_Qn} !== {1'b0, 4'd1}) begin
            n_err++; $display("FAIL reset_tail: got full=%b qn=%0d want full=0 qn=1", oIS_Full, oRF_Qn);
        end
    endtask

    task automatic test_basic();
        do_reset();
        iIS_En = 1; iIS_Rd = 5; iIS_Br = 0;
        tick();
        iRF_En = 1; iRF_Qd = 1; iRF_Qs1 = 0; iRF_Qs2 = 0; iRF_Vs1 = 32'h11; iRF_Vs2 = 32'h22;
        iRF_Op = 6'h3; iRF_Pc = 32'h100; iRF_Imm = 32'h4;
        tick();
        n_vec++;
        if ({oRS_En, oRS_Qd, oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk, oRS_Op, oRS_Pc, oRS_Imm} !==
            {1'b1, 4'd1, 4'd0, 32'h11, 4'd0, 32'h22, 6'h3, 32'h100, 32'h4}) begin
            n_err++; $display("FAIL basic_dispatch: got en=%b qd=%0d vj=%h vk=%h want en=1 qd=1 vj=11 vk=22",
                              oRS_En, oRS_Qd, oRS_Vj, oRS_Vk);
        end
        iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'h1234;
        tick();
        n_vec++;
        if ({oRF_En, oRS_En} !== 2'b00) begin
            n_err++; $display("FAIL basic_early: got rf_en=%b rs_en=%b want 0 0", oRF_En, oRS_En);
        end
        tick();
        n_vec++;
        if ({oRF_En, oRF_Rd, oRF_Vd} !== {1'b1, 5'd5, 32'h1234}) begin
            n_err++; $display("FAIL basic_commit: got en=%b rd=%0d vd=%h want en=1 rd=5 vd=1234",
                              oRF_En, oRF_Rd, oRF_Vd);
        end
        tick();
        n_vec++;
        if (oRF_En !== 1'b0) begin
            n_err++; $display("FAIL basic_pulse: got rf_en=%b want 0", oRF_En);
        end
    endtask

    task automatic test_dependent();
        do_reset();
        iIS_En = 1; iIS_Rd = 3; iIS_Br = 0;
        tick();
        iIS_En = 1; iIS_Rd = 4;
        iRF_En = 1; iRF_Qd = 1; iRF_Qs1 = 0; iRF_Qs2 = 0;
        tick();
        iIS_En = 1; iIS_Rd = 6;
        iRF_En = 1; iRF_Qd = 2; iRF_Qs1 = 1; iRF_Qs2 = 0; iRF_Vs1 = 32'h5; iRF_Vs2 = 32'h7;
        iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'hAA;
        tick();
        n_vec++;
        if ({oRS_En, oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk, oRS_Qd} !==
            {1'b1, 4'd0, 32'hAA, 4'd0, 32'h7, 4'd2}) begin
            n_err++; $display("FAIL dep_bypass: got qj=%0d vj=%h qk=%0d vk=%h want qj=0 vj=aa qk=0 vk=7",
                              oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk);
        end
        iRF_En = 1; iRF_Qd = 3; iRF_Qs1 = 3; iRF_Qs2 = 1; iRF_Vs1 = 32'h99; iRF_Vs2 = 32'h98;
        tick();
        n_vec++;
        if ({oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk} !== {4'd3, 32'h0, 4'd0, 32'hAA}) begin
            n_err++; $display("FAIL dep_pending: got qj=%0d vj=%h qk=%0d vk=%h want qj=3 vj=0 qk=0 vk=aa",
                              oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk);
        end
    endtask

    task automatic test_ooo();
        int rd_q[$];
        int cyc_q[$];
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            iIS_En = 1; iIS_Rd = AW'(i); iIS_Br = 0;
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin iCDB_En = 1; iCDB_Q = 3; iCDB_V = 32'h33; end
            if (c == 1) begin iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'h11; end
            if (c == 2) begin iCDB_En = 1; iCDB_Q = 2; iCDB_V = 32'h22; end
            tick();
            if (oRF_En === 1'b1) begin rd_q.push_back(int'(oRF_Rd)); cyc_q.push_back(c); end
        end
        n_vec++;
        if (rd_q.size() != 3) begin
            n_err++; $display("FAIL ooo_count: got %0d commits want 3", rd_q.size());
        end else begin
            n_vec++;
            if (rd_q[0] != 1 || rd_q[1] != 2 || rd_q[2] != 3) begin
                n_err++; $display("FAIL ooo_order: got rd %0d,%0d,%0d want 1,2,3", rd_q[0], rd_q[1], rd_q[2]);
            end
            n_vec++;
            if (cyc_q[0] != 2 || cyc_q[1] != 3 || cyc_q[2] != 4) begin
                n_err++; $display("FAIL ooo_timing: got cycles %0d,%0d,%0d want 2,3,4", cyc_q[0], cyc_q[1], cyc_q[2]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            iIS_En = 1; iIS_Rd = AW'(i); iIS_Br = 0;
            tick();
        end
        n_vec++;
        if ({oIS_Full, oRF_Qn} !== {1'b1, 4'd1}) begin
            n_err++; $display("FAIL full_set: got full=%b qn=%0d want full=1 qn=1", oIS_Full, oRF_Qn);
        end
        iIS_En = 1; iIS_Rd = 31;
        tick();
        n_vec++;
        if ({oIS_Full, oRF_Qn} !== {1'b1, 4'd1}) begin
            n_err++; $display("FAIL full_ignore: got full=%b qn=%0d want full=1 qn=1", oIS_Full, oRF_Qn);
        end
        iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'h77;
        tick();
        tick();
        n_vec++;
        if ({oRF_En, oRF_Rd, oRF_Vd, oIS_Full, oRF_Qn} !== {1'b1, 5'd1, 32'h77, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL full_commit: got en=%b rd=%0d vd=%h full=%b qn=%0d want 1 1 77 0 1",
                              oRF_En, oRF_Rd, oRF_Vd, oIS_Full, oRF_Qn);
        end
        iIS_En = 1; iIS_Rd = 9;
        tick();
        n_vec++;
        if ({oIS_Full, oRF_Qn} !== {1'b1, 4'd2}) begin
            n_err++; $display("FAIL full_wrap: got full=%b qn=%0d want full=1 qn=2", oIS_Full, oRF_Qn);
        end
    endtask

    task automatic test_mispredict();
        int          rd_q[$];
        bit          mp_q[$];
        int          n_mp;
        logic [DW-1:0] pc_seen;
        n_mp = 0; pc_seen = 0;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            iIS_En = 1; iIS_Rd = AW'(i); iIS_Br = (i == 2);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin iCDB_En = 1; iCDB_Q = 3; iCDB_V = 32'h3; end
            if (c == 1) begin iCDB_En = 1; iCDB_Q = 2; iCDB_V = 32'h2; iCDB_Mp = 1; iCDB_Pc = 32'h80; end
            if (c == 2) begin iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'h1; end
            tick();
            if (oRF_En === 1'b1) begin rd_q.push_back(int'(oRF_Rd)); mp_q.push_back(oMp); end
            if (oMp === 1'b1) begin n_mp++; pc_seen = oMp_Pc; end
        end
        n_vec++;
        if (rd_q.size() != 2) begin
            n_err++; $display("FAIL mp_commits: got %0d commits want 2", rd_q.size());
        end else begin
            n_vec++;
            if (rd_q[0] != 1 || rd_q[1] != 2 || mp_q[0] != 0 || mp_q[1] != 1) begin
                n_err++; $display("FAIL mp_order: got rd %0d/%0d mp %0d/%0d want rd 1/2 mp 0/1",
                                  rd_q[0], rd_q[1], mp_q[0], mp_q[1]);
            end
        end
        n_vec++;
        if (n_mp != 1 || pc_seen !== 32'h80) begin
            n_err++; $display("FAIL mp_pulse: got %0d pulses pc=%h want 1 pulse pc=80", n_mp, pc_seen);
        end
        n_vec++;
        if ({oIS_Full, oRF_Qn} !== {1'b0, 4'd1}) begin
            n_err++; $display("FAIL mp_empty: got full=%b qn=%0d want full=0 qn=1", oIS_Full, oRF_Qn);
        end
        iIS_En = 1; iIS_Rd = 7; iIS_Br = 0;
        tick();
        n_vec++;
        if (oRF_Qn !== 4'd2) begin
            n_err++; $display("FAIL mp_resume: got qn=%0d want 2", oRF_Qn);
        end
    endtask

    task automatic test_reset_mid();
        int n_commit;
        n_commit = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            iIS_En = 1; iIS_Rd = AW'(6 + i); iIS_Br = 0;
            tick();
        end
        iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'hDEAD;
        tick();
        rst = 1; iIS_En = 1; iIS_Rd = 1;
        tick();
        rst = 0;
        n_vec++;
        if ({oRS_En, oRF_En, oMp, oRF_Rd, oRF_Vd, oMp_Pc, oIS_Full, oRF_Qn} !==
            {3'b000, 5'd0, 32'd0, 32'd0, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL rstmid_outputs: got rf_en=%b rd=%0d vd=%h full=%b qn=%0d want 0 0 0 0 1",
                              oRF_En, oRF_Rd, oRF_Vd, oIS_Full, oRF_Qn);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin iCDB_En = 1; iCDB_Q = 2; iCDB_V = 32'hBEEF; end
            tick();
            if (oRF_En === 1'b1) n_commit++;
        end
        n_vec++;
        if (n_commit != 0) begin
            n_err++; $display("FAIL rstmid_commit: got %0d commits want 0", n_commit);
        end
    endtask

    task automatic test_enable();
        do_reset();
        iIS_En = 1; iIS_Rd = 9; iIS_Br = 0;
        tick();
        iCDB_En = 1; iCDB_Q = 1; iCDB_V = 32'h55;
        tick();
        tick();
        en = 0; iIS_En = 1; iIS_Rd = 4; iCDB_En = 1; iCDB_Q = 2; iCDB_V = 32'h66;
        tick();
        tick();
        n_vec++;
        if ({oRF_En, oRF_Rd, oRF_Vd, oRF_Qn} !== {1'b1, 5'd9, 32'h55, 4'd2}) begin
            n_err++; $display("FAIL en_hold: got en=%b rd=%0d vd=%h qn=%0d want 1 9 55 2",
                              oRF_En, oRF_Rd, oRF_Vd, oRF_Qn);
        end
        en = 1;
        tick();
        n_vec++;
        if ({oRF_En, oRF_Qn, oIS_Full} !== {1'b0, 4'd2, 1'b0}) begin
            n_err++; $display("FAIL en_resume: got en=%b qn=%0d full=%b want 0 2 0", oRF_En, oRF_Qn, oIS_Full);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 7) != 0);
            iIS_En  = ($urandom_range(0, 99) < ((c < 300) ? 70 : 40));
            iIS_Rd  = AW'($urandom);
            iIS_Br  = ($urandom_range(0, 3) == 0);
            iRF_En  = ($urandom_range(0, 1) == 1);
            iRF_Qs1 = ($urandom_range(0, 3) == 0) ? 4'd0 : RW'($urandom);
            iRF_Qs2 = ($urandom_range(0, 3) == 0) ? 4'd0 : RW'($urandom);
            iRF_Vs1 = $urandom; iRF_Vs2 = $urandom; iRF_Qd = RW'($urandom);
            iRF_Op  = OW'($urandom); iRF_Pc = $urandom; iRF_Imm = $urandom;
            iCDB_En = ($urandom_range(0, 99) < 50);
            iCDB_Q  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
                      mq[$urandom_range(0, mq.size() - 1)].tag : RW'($urandom);
            iCDB_V  = $urandom;
            iCDB_Mp = ($urandom_range(0, 5) == 0);
            iCDB_Pc = $urandom;
            tick();
            rst = 0;
            n_vec++;
            if ({oIS_Full, oRF_Qn} !== {1'(mq.size() == 15), RW'(mtail)}) begin
                n_err++; $display("FAIL rnd_tail c=%0d: got full=%b qn=%0d want full=%b qn=%0d",
                                  c, oIS_Full, oRF_Qn, mq.size() == 15, mtail);
            end
            n_vec++;
            if ({oRS_En, oRF_En, oMp} !== {e_rs_en, e_rf_en, e_mp}) begin
                n_err++; $display("FAIL rnd_strobes c=%0d: got rs/rf/mp=%b%b%b want %b%b%b",
                                  c, oRS_En, oRF_En, oMp, e_rs_en, e_rf_en, e_mp);
            end
            if (e_rs_en) begin
                n_vec++;
                if ({oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk, oRS_Qd, oRS_Op, oRS_Pc, oRS_Imm} !==
                    {e_qj, e_vj, e_qk, e_vk, e_qd, e_op, e_pc, e_imm}) begin
                    n_err++; $display("FAIL rnd_dispatch c=%0d: got qj=%0d vj=%h qk=%0d vk=%h want qj=%0d vj=%h qk=%0d vk=%h",
                                      c, oRS_Qj, oRS_Vj, oRS_Qk, oRS_Vk, e_qj, e_vj, e_qk, e_vk);
                end
            end
            if (e_rf_en) begin
                n_vec++;
                if ({oRF_Rd, oRF_Vd} !== {e_rd, e_vd}) begin
                    n_err++; $display("FAIL rnd_commit c=%0d: got rd=%0d vd=%h want rd=%0d vd=%h",
                                      c, oRF_Rd, oRF_Vd, e_rd, e_vd);
                end
            end
            if (e_mp) begin
                n_vec++;
                if (oMp_Pc !== e_mppc) begin
                    n_err++; $display("FAIL rnd_mppc c=%0d: got %h want %h", c, oMp_Pc, e_mppc);
                end
            end
        end
    endtask

    initial begin
        rst = 1; en = 1;
        iIS_En = 0; iIS_Rd = 0; iIS_Br = 0;
        iRF_En = 0; iRF_Qs1 = 0; iRF_Qs2 = 0; iRF_Vs1 = 0; iRF_Vs2 = 0; iRF_Qd = 0;
        iRF_Op = 0; iRF_Pc = 0; iRF_Imm = 0;
        iCDB_En = 0; iCDB_Q = 0; iCDB_V = 0; iCDB_Mp = 0; iCDB_Pc = 0;
        test_reset();
        test_basic();
        test_dependent();
        test_ooo();
        test_full();
        test_mispredict();
        test_reset_mid();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
